rram_array_sequencer: RTL and testbench

Parametrised successor to the RRAM instruction decoder. It accepts 32-bit array instructions over a valid/ready handshake and runs each one as a multi-cycle state machine: write pulses with programmable width, two-phase precharge/sense reads, and MAC operations stepped over row groups. It drives the WL/BL/SL line-voltage codes, the two sense-mux banks, the CSA/ADC enables and the precharge signal of one RRAM macro. It sits between the in-memory-compute instruction fetch and the analog array periphery.

---
 rtl/rram_pkg.sv | 32 +++
 rtl/rram_line_driver.sv | 21 ++
 rtl/rram_array_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_rram_array_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rram_pkg.sv
// Shared constants for the RRAM array sequencer: opcodes, line codes,
// FSM states and instruction field positions.
package rram_pkg;

  localparam logic [3:0] OP_WRITE  = 4'd1;
  localparam logic [3:0] OP_READ   = 4'd2;
  localparam logic [3:0] OP_MAC    = 4'd3;
  localparam logic [3:0] OP_CONF_T = 4'd4;
  localparam logic [3:0] OP_CONF_V = 4'd5;

  localparam logic [1:0] CODE_IDLE = 2'b11;
  localparam logic [1:0] CODE_READ = 2'b01;
  localparam logic [1:0] CODE_SEL  = 2'b00;

  localparam int OP_LSB     = 28;
  localparam int ROW_LSB    = 8;
  localparam int COL_LSB    = 0;
  localparam int MAC_FW     = 7;
  localparam int MAC_CS_LSB = 21;
  localparam int MAC_CE_LSB = 14;
  localparam int MAC_RS_LSB = 7;
  localparam int MAC_RE_LSB = 0;

  // Internal line-index width: holds 0..256 plus a MAC group overshoot.
  localparam int IDX_W = 9;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE, WR_PULSE, RD_PRE, RD_SENSE, MAC_PRE, MAC_CONV
  } state_t;

endpackage

// File: rtl/rram_line_driver.sv
// Range decoder: lines lo..hi get the active code, every other line idles.
module rram_line_driver
  import rram_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [IDX_W-1:0] lo,
  input  logic [IDX_W-1:0] hi,
  input  logic [1:0]       code,
  input  logic             en,
  output logic [2*N-1:0]   codes
);

  always_comb begin
    codes = {N{CODE_IDLE}};
    for (int i = 0; i < N; i++) begin
      if (en && IDX_W'(i) >= lo && IDX_W'(i) <= hi) codes[2*i +: 2] = code;
    end
  end

endmodule

// File: rtl/rram_array_sequencer.sv
// Instruction sequencer for one RRAM macro: write pulses, precharge/sense
// reads and row-group MAC, with all periphery controls driven from flops.
module rram_array_sequencer
  import rram_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int MUX_IN      = 8,
  parameter int WL_PER_STEP = 4,
  parameter int AW          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [31:0]               instruction,
  output logic                      done,
  output logic                      err_illegal,
  output logic [2*ROWS-1:0]         wl_code,
  output logic [2*COLS-1:0]         bl_code,
  output logic [2*COLS-1:0]         sl_code,
  output logic                      enable_wl,
  output logic                      enable_bl,
  output logic                      enable_sl,
  output logic                      pre,
  output logic [$clog2(MUX_IN)-1:0] s_mux1,
  output logic [$clog2(MUX_IN)-1:0] s_mux2,
  output logic                      sel_csa1,
  output logic                      sel_csa2,
  output logic                      sel_adc1,
  output logic                      sel_adc2,
  output logic                      saen_csa1,
  output logic                      saen_csa2,
  output logic                      clk_en_adc1,
  output logic                      clk_en_adc2,
  output logic                      mac_mux,
  output logic [7:0]                mac_step
);

  localparam int   SW     = $clog2(MUX_IN);
  localparam idx_t ROWS_I = IDX_W'(ROWS);
  localparam idx_t COLS_I = IDX_W'(COLS);
  localparam idx_t MUX_I  = IDX_W'(MUX_IN);
  localparam idx_t WPS_I  = IDX_W'(WL_PER_STEP);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, step_q, step_d, t_mult_q, t_mult_d;
  logic [1:0] v_sel_q, v_sel_d;
  idx_t       row_lo_q, row_lo_d, row_end_q, row_end_d;
  idx_t       col_lo_q, col_lo_d, col_hi_q, col_hi_d;
  logic       done_d, err_d;

  logic [3:0] op;
  idx_t       row_f, col_f, mcs, mce, mrs, mre;
  logic       rw_bad, mac_bad;

  assign op      = instruction[OP_LSB +: 4];
  assign row_f   = idx_t'(instruction[ROW_LSB +: AW]);
  assign col_f   = idx_t'(instruction[COL_LSB +: AW]);
  assign mcs     = idx_t'(instruction[MAC_CS_LSB +: MAC_FW]);
  assign mce     = idx_t'(instruction[MAC_CE_LSB +: MAC_FW]);
  assign mrs     = idx_t'(instruction[MAC_RS_LSB +: MAC_FW]);
  assign mre     = idx_t'(instruction[MAC_RE_LSB +: MAC_FW]);
  assign rw_bad  = (row_f >= ROWS_I) || (col_f >= COLS_I);
  assign mac_bad = (mrs > mre) || (mcs > mce) || (mre >= ROWS_I) || (mce >= COLS_I);

  assign instr_ready = (state_q == IDLE);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    t_mult_d  = t_mult_q;
    v_sel_d   = v_sel_q;
    row_lo_d  = row_lo_q;
    row_end_d = row_end_q;
    col_lo_d  = col_lo_q;
    col_hi_d  = col_hi_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: if (instr_valid) begin
        done_d = 1'b1;
        case (op)
          OP_WRITE, OP_READ: begin
            if (rw_bad) begin
              err_d = 1'b1;
            end else begin
              done_d    = 1'b0;
              state_d   = (op == OP_WRITE) ? WR_PULSE : RD_PRE;
              cnt_d     = t_mult_q;
              row_lo_d  = row_f;
              row_end_d = row_f;
              col_lo_d  = col_f;
              col_hi_d  = col_f;
            end
          end
          OP_MAC: begin
            if (mac_bad) begin
              err_d = 1'b1;
            end else begin
              done_d    = 1'b0;
              state_d   = MAC_PRE;
              step_d    = 8'd0;
              row_lo_d  = mrs;
              row_end_d = mre;
              col_lo_d  = mcs;
              col_hi_d  = mce;
            end
          end
          OP_CONF_T: t_mult_d = instruction[7:0];
          OP_CONF_V: v_sel_d  = instruction[1:0];
          default:   err_d    = 1'b1;
        endcase
      end
      WR_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RD_PRE:   state_d = RD_SENSE;
      RD_SENSE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      MAC_PRE:  state_d = MAC_CONV;
      MAC_CONV: begin
        if (row_lo_q + WPS_I > row_end_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d  = MAC_PRE;
          row_lo_d = row_lo_q + WPS_I;
          step_d   = step_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode works on next-state values so the flops below present
  // the active pattern in the first cycle after acceptance.
  idx_t       wl_hi_d;
  logic       wl_on, col_on, bank1, bank2;
  logic [1:0] bl_val, sl_val, wr_code;
  logic       en_wl_d, en_bl_d, en_sl_d, pre_d, mac_mux_d;
  logic       sel_csa1_d, sel_csa2_d, sel_adc1_d, sel_adc2_d;
  logic       saen1_d, saen2_d, clk_en1_d, clk_en2_d;
  logic [SW-1:0] s_mux1_d, s_mux2_d;
  logic [7:0]    mac_step_d;
  logic [2*ROWS-1:0] wl_code_d;
  logic [2*COLS-1:0] bl_code_d, sl_code_d;

  assign wl_hi_d = (row_lo_d + WPS_I - idx_t'(1) < row_end_d) ?
                   row_lo_d + WPS_I - idx_t'(1) : row_end_d;
  assign bank1   = col_lo_d < MUX_I;
  assign bank2   = col_hi_d >= MUX_I;
  assign wr_code = (v_sel_q == 2'b11) ? CODE_SEL : v_sel_q;

  always_comb begin
    wl_on = 1'b0;  col_on = 1'b0;
    bl_val = CODE_IDLE;  sl_val = CODE_IDLE;
    en_wl_d = 1'b0;  en_bl_d = 1'b0;  en_sl_d = 1'b0;  pre_d = 1'b1;
    sel_csa1_d = 1'b0;  sel_csa2_d = 1'b0;  sel_adc1_d = 1'b0;  sel_adc2_d = 1'b0;
    saen1_d = 1'b0;  saen2_d = 1'b0;  clk_en1_d = 1'b0;  clk_en2_d = 1'b0;
    s_mux1_d = '0;  s_mux2_d = '0;  mac_mux_d = 1'b0;  mac_step_d = 8'd0;
    unique case (state_d)
      WR_PULSE: begin
        wl_on = 1'b1;  col_on = 1'b1;
        bl_val = wr_code;  sl_val = wr_code;
        en_wl_d = 1'b1;  en_bl_d = 1'b1;  en_sl_d = 1'b1;
      end
      RD_PRE, RD_SENSE: begin
        wl_on = 1'b1;  col_on = 1'b1;
        bl_val = CODE_READ;  sl_val = CODE_SEL;
        // MUX_IN is a power of two, so the low bits are the in-bank column.
        sel_csa1_d = bank1;  sel_csa2_d = !bank1;
        if (bank1) s_mux1_d = col_lo_d[SW-1:0];
        else       s_mux2_d = col_lo_d[SW-1:0];
        if (state_d == RD_PRE) begin
          pre_d = 1'b0;
        end else begin
          en_wl_d = 1'b1;  en_bl_d = 1'b1;
          saen1_d = bank1;  saen2_d = !bank1;
        end
      end
      MAC_PRE, MAC_CONV: begin
        wl_on = 1'b1;  col_on = 1'b1;
        bl_val = CODE_READ;  sl_val = CODE_SEL;
        mac_mux_d = 1'b1;  mac_step_d = step_d;
        sel_adc1_d = bank1;  sel_adc2_d = bank2;
        if (state_d == MAC_PRE) begin
          pre_d = 1'b0;
        end else begin
          en_wl_d = 1'b1;  en_bl_d = 1'b1;
          clk_en1_d = bank1;  clk_en2_d = bank2;
        end
      end
      default: ;
    endcase
  end

  rram_line_driver #(.N(ROWS)) u_wl (
    .lo(row_lo_d), .hi(wl_hi_d), .code(CODE_SEL), .en(wl_on), .codes(wl_code_d)
  );
  rram_line_driver #(.N(COLS)) u_bl (
    .lo(col_lo_d), .hi(col_hi_d), .code(bl_val), .en(col_on), .codes(bl_code_d)
  );
  rram_line_driver #(.N(COLS)) u_sl (
    .lo(col_lo_d), .hi(col_hi_d), .code(sl_val), .en(col_on), .codes(sl_code_d)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;  step_q    <= '0;
      t_mult_q <= '0;  v_sel_q   <= '0;
      row_lo_q <= '0;  row_end_q <= '0;
      col_lo_q <= '0;  col_hi_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;     step_q    <= step_d;
      t_mult_q <= t_mult_d;  v_sel_q   <= v_sel_d;
      row_lo_q <= row_lo_d;  row_end_q <= row_end_d;
      col_lo_q <= col_lo_d;  col_hi_q  <= col_hi_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;  err_illegal <= 1'b0;
      wl_code <= '1;  bl_code <= '1;  sl_code <= '1;
      enable_wl <= 1'b0;  enable_bl <= 1'b0;  enable_sl <= 1'b0;  pre <= 1'b1;
      s_mux1 <= '0;  s_mux2 <= '0;
      sel_csa1 <= 1'b0;  sel_csa2 <= 1'b0;  sel_adc1 <= 1'b0;  sel_adc2 <= 1'b0;
      saen_csa1 <= 1'b0;  saen_csa2 <= 1'b0;  clk_en_adc1 <= 1'b0;  clk_en_adc2 <= 1'b0;
      mac_mux <= 1'b0;  mac_step <= '0;
    end else begin
      done <= done_d;  err_illegal <= err_d;
      wl_code <= wl_code_d;  bl_code <= bl_code_d;  sl_code <= sl_code_d;
      enable_wl <= en_wl_d;  enable_bl <= en_bl_d;  enable_sl <= en_sl_d;  pre <= pre_d;
      s_mux1 <= s_mux1_d;  s_mux2 <= s_mux2_d;
      sel_csa1 <= sel_csa1_d;  sel_csa2 <= sel_csa2_d;
      sel_adc1 <= sel_adc1_d;  sel_adc2 <= sel_adc2_d;
      saen_csa1 <= saen1_d;  saen_csa2 <= saen2_d;
      clk_en_adc1 <= clk_en1_d;  clk_en_adc2 <= clk_en2_d;
      mac_mux <= mac_mux_d;  mac_step <= mac_step_d;
    end
  end

endmodule

// File: tb/tb_rram_array_sequencer.sv
// Directed bench for rram_array_sequencer: a vector table of single
// instructions plus hand-written write, read, MAC and reset sequences.
module tb_rram_array_sequencer;

  logic        clk, rst, instr_valid, instr_ready, done, err_illegal;
  logic [31:0] instruction;
  logic [31:0] wl_code, bl_code, sl_code;
  logic        enable_wl, enable_bl, enable_sl, pre;
  logic [2:0]  s_mux1, s_mux2;
  logic        sel_csa1, sel_csa2, sel_adc1, sel_adc2;
  logic        saen_csa1, saen_csa2, clk_en_adc1, clk_en_adc2, mac_mux;
  logic [7:0]  mac_step;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ALL_IDLE = 32'hFFFF_FFFF;

  rram_array_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .done(done), .err_illegal(err_illegal),
    .wl_code(wl_code), .bl_code(bl_code), .sl_code(sl_code),
    .enable_wl(enable_wl), .enable_bl(enable_bl), .enable_sl(enable_sl), .pre(pre),
    .s_mux1(s_mux1), .s_mux2(s_mux2), .sel_csa1(sel_csa1), .sel_csa2(sel_csa2),
    .sel_adc1(sel_adc1), .sel_adc2(sel_adc2), .saen_csa1(saen_csa1),
    .saen_csa2(saen_csa2), .clk_en_adc1(clk_en_adc1), .clk_en_adc2(clk_en_adc2),
    .mac_mux(mac_mux), .mac_step(mac_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] wl, bl, sl;
    logic [2:0]  en;
    logic        pre;
    int          lat;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [31:0] ins, logic [31:0] wl,
                              logic [31:0] bl, logic [31:0] sl, logic [2:0] en,
                              logic p, int lat, logic err);
    vec_t v;
    v.name = n; v.ins = ins; v.wl = wl; v.bl = bl; v.sl = sl;
    v.en = en; v.pre = p; v.lat = lat; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] lines(int lo, int hi, logic [1:0] c);
    logic [31:0] v;
    v = ALL_IDLE;
    for (int i = 0; i < 16; i++) if (i >= lo && i <= hi) v[2*i +: 2] = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    instr_valid = 1'b1;
    instruction = ins;
    step();
    instr_valid = 1'b0;
    instruction = '0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic check_idle(input string n);
    check({n, "_wl"}, 64'(wl_code), 64'(ALL_IDLE));
    check({n, "_bl"}, 64'(bl_code), 64'(ALL_IDLE));
    check({n, "_sl"}, 64'(sl_code), 64'(ALL_IDLE));
    check({n, "_en_pre"}, 64'({enable_wl, enable_bl, enable_sl, pre}), 64'(4'b0001));
    check({n, "_misc"}, 64'({s_mux1, s_mux2, sel_csa1, sel_csa2, sel_adc1, sel_adc2,
                             saen_csa1, saen_csa2, clk_en_adc1, clk_en_adc2, mac_mux,
                             mac_step}), 64'(0));
  endtask

  initial begin
    int cyc;
    vec_t v;
    rst = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;

    vecs.push_back(mk("conf_t3",  32'h4000_0003, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b0));
    vecs.push_back(mk("conf_v2",  32'h5000_0002, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b0));
    vecs.push_back(mk("wr_r5c2",  32'h1000_0502, 32'hFFFF_F3FF, 32'hFFFF_FFEF, 32'hFFFF_FFEF, 3'b111, 1'b1, 5, 1'b0));
    vecs.push_back(mk("rd_r3c12", 32'h2000_030C, 32'hFFFF_FF3F, 32'hFDFF_FFFF, 32'hFCFF_FFFF, 3'b000, 1'b0, 3, 1'b0));
    vecs.push_back(mk("op_f",     32'hF000_0000, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b1));
    vecs.push_back(mk("mac_rrev", 32'h3000_0482, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b1));
    vecs.push_back(mk("wr_row16", 32'h1000_1000, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b1));
    vecs.push_back(mk("rd_col16", 32'h2000_0010, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b1));
    vecs.push_back(mk("mac_crev", 32'h3140_C000, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b1));
    vecs.push_back(mk("op_0",     32'h0000_0000, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b1));
    vecs.push_back(mk("conf_v3",  32'h5000_0003, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b0));
    vecs.push_back(mk("wr_r0c15", 32'h1000_000F, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 3'b111, 1'b1, 5, 1'b0));
    vecs.push_back(mk("conf_t0",  32'h4000_0000, ALL_IDLE, ALL_IDLE, ALL_IDLE, 3'b000, 1'b1, 1, 1'b0));
    vecs.push_back(mk("wr_r15c0", 32'h1000_0F00, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 3'b111, 1'b1, 2, 1'b0));
    vecs.push_back(mk("rd_r0c7",  32'h2000_0007, 32'hFFFF_FFFC, 32'hFFFF_7FFF, 32'hFFFF_3FFF, 3'b000, 1'b0, 3, 1'b0));
    vecs.push_back(mk("mac_full", 32'h3003_C00F, 32'hFFFF_FF00, 32'h5555_5555, 32'h0000_0000, 3'b000, 1'b0, 9, 1'b0));

    // Reset release, then five idle cycles.
    repeat (3) step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rst%0d_ready", i), 64'(instr_ready), 64'(1));
      check($sformatf("rst%0d_done", i), 64'({done, err_illegal}), 64'(0));
      check_idle($sformatf("rst%0d", i));
    end

    // Vector table: first active cycle, completion latency and outcome.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      issue(v.ins);
      check({v.name, "_wl"}, 64'(wl_code), 64'(v.wl));
      check({v.name, "_bl"}, 64'(bl_code), 64'(v.bl));
      check({v.name, "_sl"}, 64'(sl_code), 64'(v.sl));
      check({v.name, "_en"}, 64'({enable_wl, enable_bl, enable_sl}), 64'(v.en));
      check({v.name, "_pre"}, 64'(pre), 64'(v.pre));
      check({v.name, "_ready"}, 64'(instr_ready), 64'(v.lat == 1));
      wait_done(cyc);
      check({v.name, "_lat"}, 64'(cyc), 64'(v.lat));
      check({v.name, "_err"}, 64'(err_illegal), 64'(v.err));
      check({v.name, "_end_wl"}, 64'(wl_code), 64'(ALL_IDLE));
    end

    // Write pulse width, issued back-to-back after two config updates.
    issue(32'h4000_0003);
    check("bb_conf_t_done", 64'(done), 64'(1));
    issue(32'h5000_0002);
    check("bb_conf_v_done", 64'(done), 64'(1));
    issue(32'h1000_0502);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("wr_c%0d_wl", c), 64'(wl_code), 64'(lines(5, 5, 2'b00)));
      check($sformatf("wr_c%0d_bl", c), 64'(bl_code), 64'(lines(2, 2, 2'b10)));
      check($sformatf("wr_c%0d_sl", c), 64'(sl_code), 64'(lines(2, 2, 2'b10)));
      check($sformatf("wr_c%0d_en", c), 64'({enable_wl, enable_bl, enable_sl, done}), 64'(4'b1110));
      step();
    end
    check("wr_done", 64'({done, err_illegal, instr_ready}), 64'(3'b101));
    check_idle("wr_end");

    // Read on bank 2.
    issue(32'h2000_030C);
    check("rd_pre", 64'({pre, sel_csa1, sel_csa2, saen_csa2, enable_wl}), 64'(5'b00100));
    step();
    check("rd_sense", 64'({pre, enable_wl, enable_bl, enable_sl, sel_csa2, saen_csa1, saen_csa2}),
          64'(7'b1110101));
    check("rd_smux2", 64'(s_mux2), 64'(4));
    step();
    check("rd_done", 64'(done), 64'(1));
    check_idle("rd_end");

    // MAC rows 1..10, cols 3..9: three row groups over both banks.
    issue(32'h3062_408A);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mac%0d_pre_step", k), 64'({mac_mux, mac_step}), 64'({1'b1, 8'(k)}));
      check($sformatf("mac%0d_pre_wl", k), 64'(wl_code),
            64'(lines(1 + 4*k, (4 + 4*k > 10) ? 10 : 4 + 4*k, 2'b00)));
      check($sformatf("mac%0d_pre_bl", k), 64'(bl_code), 64'(lines(3, 9, 2'b01)));
      check($sformatf("mac%0d_pre_sl", k), 64'(sl_code), 64'(lines(3, 9, 2'b00)));
      check($sformatf("mac%0d_pre_ctl", k),
            64'({pre, enable_wl, sel_adc1, sel_adc2, clk_en_adc1, clk_en_adc2, done}),
            64'(7'b0011000));
      step();
      check($sformatf("mac%0d_conv_ctl", k),
            64'({pre, enable_wl, enable_bl, enable_sl, sel_adc1, sel_adc2, clk_en_adc1,
                 clk_en_adc2, done}), 64'(9'b111011110));
      check($sformatf("mac%0d_conv_step", k), 64'(mac_step), 64'(k));
      step();
    end
    check("mac_done", 64'(done), 64'(1));
    check_idle("mac_end");

    // Reset during the second cycle of a four-cycle write.
    issue(32'h4000_0003);
    issue(32'h1000_0502);
    step();
    check("rstw_active", 64'({enable_wl, done}), 64'(2'b10));
    #2 rst = 1'b0;
    #1;
    check("rstw_flags", 64'({done, err_illegal, instr_ready}), 64'(3'b001));
    check_idle("rstw");
    #2 rst = 1'b1;
    step();
    check("rstw_no_done", 64'(done), 64'(0));
    issue(32'h2000_030C);
    check("post_rd_pre", 64'({pre, sel_csa2}), 64'(2'b01));
    step();
    check("post_rd_sense", 64'({pre, saen_csa2, s_mux2}), 64'({2'b11, 3'd4}));
    step();
    check("post_rd_done", 64'(done), 64'(1));
    // Config was cleared by reset: one-cycle pulse with code 00.
    issue(32'h1000_0502);
    check("post_wr_bl", 64'(bl_code), 64'(lines(2, 2, 2'b00)));
    step();
    check("post_wr_done", 64'(done), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
